// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage pipe.
// Drives the IF/ID, ID/EX and EX/MEM load enables, the IF/ID flush and the
// ID/EX bubble. It resolves load-use hazards, taken-branch refill and
// data-memory wait stalls. It also keeps saturating stall/flush counters and
// a sticky memory-wait watchdog. State updates on the falling clock edge, in
// step with the pipeline registers it controls.
module pipe_hazard_ctrl #(
    parameter int unsigned REFILL_CYC = 1,   // 0..15
    parameter int unsigned WAIT_MAX   = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic                 id_use_rs1_i,
    input  logic                 id_use_rs2_i,
    input  logic [4:0]           ex_rd_i,
    input  logic                 ex_mem_read_i,
    input  logic                 ex_br_taken_i,
    input  logic                 dmem_busy_i,
    input  logic                 perf_clr_i,
    output logic                 pc_write_o,
    output logic                 if_id_write_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_write_o,
    output logic                 id_ex_bubble_o,
    output logic                 ex_mem_write_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o,
    output logic                 wdog_err_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    localparam int unsigned WCW = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);
    localparam logic [3:0]     REFILL_LD = 4'(REFILL_CYC);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [3:0]           refill_q, refill_d;
    logic [WCW-1:0]       wait_q, wait_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [CNT_WIDTH-1:0] flush_q, flush_d;
    logic                 wdog_q, wdog_d;

    logic load_use;
    logic flush_evt;
    logic [WCW-1:0] wait_inc;

    assign load_use = ex_mem_read_i & (ex_rd_i != 5'd0) &
                      ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

    // Busy cycles count up but hold at the watchdog limit.
    assign wait_inc = (wait_q == WAIT_LIM) ? wait_q : wait_q + 1'b1;

    // Next-state, pipeline-control outputs and counter updates.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the branches below leaves one unassigned (no latches).
        state_d        = state_q;
        refill_d       = refill_q;
        wait_d         = '0;
        flush_evt      = 1'b0;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_write_o  = 1'b1;
        id_ex_bubble_o = 1'b0;
        ex_mem_write_o = 1'b1;

        if (dmem_busy_i) begin
            // Freeze the whole pipe; branch/hazard get re-evaluated when
            // busy drops because every register held its contents.
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            if (state_q == ST_RUN) begin
                state_d = ST_WAIT;
                wait_d  = {{(WCW-1){1'b0}}, 1'b1};
            end else begin
                // WAIT keeps waiting; REFILL keeps its state and its counter.
                wait_d = wait_inc;
                if (state_q != ST_REFILL) begin
                    state_d = ST_WAIT;
                end
            end
        end else if (ex_br_taken_i) begin
            // Squash the wrong-path instructions in IF/ID and ID; any
            // load-use against the squashed ID instruction is irrelevant.
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            flush_evt      = 1'b1;
            if (REFILL_CYC > 0) begin
                state_d  = ST_REFILL;
                refill_d = REFILL_LD;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_REFILL) begin
            // Fetch is still returning invalid instructions: keep flushing.
            if_id_flush_o = 1'b1;
            if (refill_q <= 4'd1) begin
                state_d  = ST_RUN;
                refill_d = '0;
            end else begin
                refill_d = refill_q - 4'd1;
            end
        end else begin
            // RUN, or the cycle WAIT is released: plain RUN rules.
            state_d = ST_RUN;
            if (load_use) begin
                // Hold PC and IF/ID one cycle; the load moves on to MEM so
                // exactly one bubble resolves the hazard.
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end
        end

        // Performance counters and watchdog; a clear wins over any update.
        stall_d = stall_q;
        flush_d = flush_q;
        wdog_d  = wdog_q | (wait_d == WAIT_LIM);
        if (!pc_write_o && stall_q != CNT_MAX) begin
            stall_d = stall_q + 1'b1;
        end
        if (flush_evt && flush_q != CNT_MAX) begin
            flush_d = flush_q + 1'b1;
        end
        if (perf_clr_i) begin
            stall_d = '0;
            flush_d = '0;
            wdog_d  = 1'b0;
        end
    end

    // State, refill/wait counters, perf counters and watchdog flag.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            refill_q <= '0;
            wait_q   <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            wdog_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before this edge, independent of statement order.
            state_q  <= state_d;
            refill_q <= refill_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            wdog_q   <= wdog_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
    assign wdog_err_o  = wdog_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (REFILL_CYC=2, WAIT_MAX=4, 4-bit
// counters so saturation is reachable). Each step drives inputs just after
// the falling edge, queues the expected outputs, and compares them at the
// following rising edge.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    // Enable vector order: {pc, if_id_write, if_id_flush, id_ex_write,
    //                       id_ex_bubble, ex_mem_write}
    localparam logic [5:0] EN_IDLE = 6'b110101;
    localparam logic [5:0] EN_HOLD = 6'b000000;
    localparam logic [5:0] EN_LU   = 6'b000111;
    localparam logic [5:0] EN_BR   = 6'b111111;
    localparam logic [5:0] EN_REF  = 6'b111101;

    logic          clk_i;
    logic          rst_ni;
    logic [4:0]    id_rs1_i, id_rs2_i, ex_rd_i;
    logic          id_use_rs1_i, id_use_rs2_i;
    logic          ex_mem_read_i, ex_br_taken_i, dmem_busy_i, perf_clr_i;
    logic          pc_write_o, if_id_write_o, if_id_flush_o;
    logic          id_ex_write_o, id_ex_bubble_o, ex_mem_write_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;
    logic          wdog_err_o;

    typedef struct {
        string      tag;
        logic [5:0] en;
        logic [1:0] st;
        int         stall;
        int         flush;
        logic       wdog;
        bit         wdog_chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pipe_hazard_ctrl #(
        .REFILL_CYC (2),
        .WAIT_MAX   (4),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_use_rs1_i   (id_use_rs1_i),
        .id_use_rs2_i   (id_use_rs2_i),
        .ex_rd_i        (ex_rd_i),
        .ex_mem_read_i  (ex_mem_read_i),
        .ex_br_taken_i  (ex_br_taken_i),
        .dmem_busy_i    (dmem_busy_i),
        .perf_clr_i     (perf_clr_i),
        .pc_write_o     (pc_write_o),
        .if_id_write_o  (if_id_write_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_write_o  (id_ex_write_o),
        .id_ex_bubble_o (id_ex_bubble_o),
        .ex_mem_write_o (ex_mem_write_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .wdog_err_o     (wdog_err_o)
    );

    initial clk_i = 1'b1;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs now.
    task automatic score();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, ".en"}, 32'({pc_write_o, if_id_write_o, if_id_flush_o,
                                    id_ex_write_o, id_ex_bubble_o, ex_mem_write_o}), 32'(e.en));
        check({e.tag, ".state"}, 32'(state_o), 32'(e.st));
        check({e.tag, ".stall"}, 32'(stall_cnt_o), 32'(e.stall));
        check({e.tag, ".flush"}, 32'(flush_cnt_o), 32'(e.flush));
        if (e.wdog_chk) check({e.tag, ".wdog"}, 32'(wdog_err_o), 32'(e.wdog));
    endtask

    task automatic push(input string tag, input logic [5:0] en, input logic [1:0] st,
                        input int stall, input int flush, input logic wdog, input bit wchk);
        exp_t e;
        e.tag = tag; e.en = en; e.st = st; e.stall = stall;
        e.flush = flush; e.wdog = wdog; e.wdog_chk = wchk;
        sb_q.push_back(e);
    endtask

    // One pipeline cycle: expectation queued, compared mid-cycle, then
    // advance past the falling edge so the next inputs can be driven.
    task automatic cyc(input string tag, input logic [5:0] en, input logic [1:0] st,
                       input int stall, input int flush, input logic wdog, input bit wchk = 1'b1);
        push(tag, en, st, stall, flush, wdog, wchk);
        @(posedge clk_i);
        score();
        @(negedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic br, input logic busy, input logic clr);
        id_rs1_i = rs1; id_rs2_i = rs2; id_use_rs1_i = u1; id_use_rs2_i = u2;
        ex_rd_i = rd; ex_mem_read_i = mr; ex_br_taken_i = br;
        dmem_busy_i = busy; perf_clr_i = clr;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        #1;
        push("reset", EN_IDLE, 2'd0, 0, 0, 1'b0, 1'b1);
        score();
        rst_ni = 1'b1;

        cyc("idle", EN_IDLE, 2'd0, 0, 0, 1'b0);

        // Load-use on rs2, then the same pattern against x0 (no hazard).
        drive(3, 5, 1, 1, 5, 1, 0, 0, 0);  cyc("lu_rs2",   EN_LU,   2'd0, 0, 0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("lu_after", EN_IDLE, 2'd0, 1, 0, 1'b0);
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0);  cyc("lu_x0",    EN_IDLE, 2'd0, 1, 0, 1'b0);
        drive(7, 2, 1, 0, 7, 1, 0, 0, 0);  cyc("lu_rs1",   EN_LU,   2'd0, 1, 0, 1'b0);
        drive(7, 2, 0, 0, 7, 1, 0, 0, 0);  cyc("lu_nouse", EN_IDLE, 2'd0, 2, 0, 1'b0);

        // Taken branch with two refill cycles.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);  cyc("br",       EN_BR,   2'd0, 2, 0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("refill1",  EN_REF,  2'd2, 2, 1, 1'b0);
                                           cyc("refill2",  EN_REF,  2'd2, 2, 1, 1'b0);
                                           cyc("br_done",  EN_IDLE, 2'd0, 2, 1, 1'b0);

        // Branch together with load-use: branch wins, no stall; then
        // busy during refill freezes the refill counter.
        drive(0, 5, 0, 1, 5, 1, 1, 0, 0);  cyc("br_lu",    EN_BR,   2'd0, 2, 1, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("brlu_r1",  EN_REF,  2'd2, 2, 2, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc("ref_busy", EN_HOLD, 2'd2, 2, 2, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("brlu_r2",  EN_REF,  2'd2, 3, 2, 1'b0);
                                           cyc("brlu_end", EN_IDLE, 2'd0, 3, 2, 1'b0);

        // Busy for three cycles with the branch held; flush fires on release.
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);  cyc("bb1",      EN_HOLD, 2'd0, 3, 2, 1'b0);
                                           cyc("bb2",      EN_HOLD, 2'd1, 4, 2, 1'b0);
                                           cyc("bb3",      EN_HOLD, 2'd1, 5, 2, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);  cyc("bb_rel",   EN_BR,   2'd1, 6, 2, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("bb_r1",    EN_REF,  2'd2, 6, 3, 1'b0);
                                           cyc("bb_r2",    EN_REF,  2'd2, 6, 3, 1'b0);
                                           cyc("bb_end",   EN_IDLE, 2'd0, 6, 3, 1'b0);

        // Watchdog: busy for six cycles with WAIT_MAX=4.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc("wd1",      EN_HOLD, 2'd0, 6, 3, 1'b0);
                                           cyc("wd2",      EN_HOLD, 2'd1, 7, 3, 1'b0);
                                           cyc("wd3",      EN_HOLD, 2'd1, 8, 3, 1'b0);
                                           cyc("wd4",      EN_HOLD, 2'd1, 9, 3, 1'b0, 1'b0);
                                           cyc("wd5",      EN_HOLD, 2'd1, 10, 3, 1'b1);
                                           cyc("wd6",      EN_HOLD, 2'd1, 11, 3, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("wd_rel",   EN_IDLE, 2'd1, 12, 3, 1'b1);
                                           cyc("wd_stick", EN_IDLE, 2'd0, 12, 3, 1'b1);

        // Stall counter saturates at all-ones.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc("sat1",     EN_HOLD, 2'd0, 12, 3, 1'b1);
                                           cyc("sat2",     EN_HOLD, 2'd1, 13, 3, 1'b1);
                                           cyc("sat3",     EN_HOLD, 2'd1, 14, 3, 1'b1);
                                           cyc("sat4",     EN_HOLD, 2'd1, 15, 3, 1'b1);
                                           cyc("sat5",     EN_HOLD, 2'd1, 15, 3, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("sat_rel",  EN_IDLE, 2'd1, 15, 3, 1'b1);

        // Clear in the same cycle as a stall increment: clear wins.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);  cyc("clr",      EN_HOLD, 2'd0, 15, 3, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("clr_done", EN_IDLE, 2'd1, 0, 0, 1'b0);

        // Asynchronous reset in the middle of REFILL.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);  cyc("rbr",      EN_BR,   2'd0, 0, 0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("rref",     EN_REF,  2'd2, 0, 1, 1'b0);
        #1;
        rst_ni = 1'b0;
        #1;
        push("async_rst", EN_IDLE, 2'd0, 0, 0, 1'b0, 1'b1);
        score();
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        cyc("post_rst", EN_IDLE, 2'd0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
